// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern transmitter: state encoding and default sizes.
package seq_gen_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCntW  = 4;

  // 3-bit encoding matches the debug width used by the detector blocks.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StLoad  = LOAD,
    StShift = SHIFT,
    StDone  = DONE
  } state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Pattern holding register with a down bit counter and the registered serial bit.
module seq_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             rewind_i,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o,
  output logic             last_o
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [BitW-1:0] LastIdx = BitW'(WIDTH - 1);

  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic             bit_q, bit_d;
  logic [BitW-1:0]  prev_idx;

  assign prev_idx = bitcnt_q - BitW'(1);

  always_comb begin
    pattern_d = pattern_q;
    bitcnt_d  = bitcnt_q;
    bit_d     = bit_q;
    if (load_i) begin
      pattern_d = data_i;
    end
    if (clear_i) begin
      bit_d = 1'b0;
    end else if (rewind_i) begin
      bitcnt_d = LastIdx;
      bit_d    = pattern_q[WIDTH-1];
    end else if (step_i) begin
      bitcnt_d = prev_idx;
      bit_d    = pattern_q[prev_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pattern_q <= '0;
      bitcnt_q  <= '0;
      bit_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      bitcnt_q  <= bitcnt_d;
      bit_q     <= bit_d;
    end
  end

  assign bit_o  = bit_q;
  assign last_o = (bitcnt_q == '0);

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, optionally repeated.
module seq_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             serialout,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] repcnt_q, repcnt_d;
  logic             valid_q, valid_d;
  logic             sr_load, sr_rewind, sr_step, sr_clear;
  logic             sr_last;

  seq_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (sr_load),
    .rewind_i(sr_rewind),
    .step_i  (sr_step),
    .clear_i (sr_clear),
    .data_i  (data_in),
    .bit_o   (serialout),
    .last_o  (sr_last)
  );

  always_comb begin
    state_d   = state_q;
    repcnt_d  = repcnt_q;
    valid_d   = 1'b0;
    sr_load   = 1'b0;
    sr_rewind = 1'b0;
    sr_step   = 1'b0;
    sr_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_load  = 1'b1;
          repcnt_d = repeat_n;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        sr_rewind = 1'b1;
        valid_d   = 1'b1;
        state_d   = StShift;
      end
      StShift: begin
        if (en) begin
          if (!sr_last) begin
            sr_step = 1'b1;
            valid_d = 1'b1;
          end else if (repcnt_q != '0) begin
            // Next frame starts on the very next cycle, no idle gap.
            sr_rewind = 1'b1;
            repcnt_d  = repcnt_q - CNT_W'(1);
            valid_d   = 1'b1;
          end else begin
            sr_clear = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      repcnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      repcnt_q <= repcnt_d;
      valid_q  <= valid_d;
    end
  end

  assign valid = valid_q;
  assign busy  = (state_q == StLoad) || (state_q == StShift);
  assign done  = (state_q == StDone);
  assign state = state_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: reset, single frame, repeats, stalls, ignored inputs, abort.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       en;
  logic [7:0] data_in;
  logic [3:0] repeat_n;
  logic       serialout;
  logic       valid;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  seq_generator #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .data_in  (data_in),
    .repeat_n (repeat_n),
    .serialout(serialout),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; en = 1'b1; data_in = 8'hAA; repeat_n = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({state, serialout, valid, busy, done} !== 7'b0) begin
        $display("FAIL reset_outputs: got %b expected 0000000",
                 {state, serialout, valid, busy, done});
        fails++;
      end
    end
    rst = 1'b1;
    step();
    tests++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      $display("FAIL reset_release_load: got state=%0d busy=%b expected state=1 busy=1",
               state, busy);
      fails++;
    end
    start = 1'b0;
    repeat (12) step();
    tests++;
    if (state !== 3'd0) begin
      $display("FAIL reset_drain_idle: got state=%0d expected 0", state);
      fails++;
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp;
    exp = 8'b1011_0101;
    data_in = 8'hB5; repeat_n = 4'd0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (state !== 3'd1 || valid !== 1'b0) begin
      $display("FAIL single_load: got state=%0d valid=%b expected state=1 valid=0", state, valid);
      fails++;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i] || busy !== 1'b1) begin
        $display("FAIL single_bit%0d: got v=%b s=%b b=%b expected v=1 s=%b b=1",
                 i, valid, serialout, busy, exp[7-i]);
        fails++;
      end
    end
    step();
    tests++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || state !== 3'd3) begin
      $display("FAIL single_done: got v=%b d=%b b=%b st=%0d expected v=0 d=1 b=0 st=3",
               valid, done, busy, state);
      fails++;
    end
    step();
    tests++;
    if (state !== 3'd0 || done !== 1'b0) begin
      $display("FAIL single_idle: got st=%0d d=%b expected st=0 d=0", state, done);
      fails++;
    end
  endtask

  task automatic test_repeat();
    logic [7:0] exp;
    exp = 8'b1111_0000;
    data_in = 8'hF0; repeat_n = 4'd2; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7 - (i % 8)] || done !== 1'b0) begin
        $display("FAIL repeat_bit%0d: got v=%b s=%b d=%b expected v=1 s=%b d=0",
                 i, valid, serialout, done, exp[7 - (i % 8)]);
        fails++;
      end
    end
    step();
    tests++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      $display("FAIL repeat_done: got d=%b v=%b expected d=1 v=0", done, valid);
      fails++;
    end
    step();
    tests++;
    if (done !== 1'b0 || state !== 3'd0) begin
      $display("FAIL repeat_single_pulse: got d=%b st=%0d expected d=0 st=0", done, state);
      fails++;
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    int         nvalid;
    exp = 8'b1011_0101;
    nvalid = 0;
    data_in = 8'hB5; repeat_n = 4'd0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b0;
    step();
    if (valid === 1'b1) nvalid++;
    tests++;
    if (valid !== 1'b1 || serialout !== 1'b1) begin
      $display("FAIL stall_load_ignores_en: got v=%b s=%b expected v=1 s=1", valid, serialout);
      fails++;
    end
    en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      if (valid === 1'b1) nvalid++;
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i]) begin
        $display("FAIL stall_pre_bit%0d: got v=%b s=%b expected v=1 s=%b",
                 i, valid, serialout, exp[7-i]);
        fails++;
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (valid !== 1'b0 || serialout !== 1'b1 || busy !== 1'b1) begin
        $display("FAIL stall_hold%0d: got v=%b s=%b b=%b expected v=0 s=1 b=1",
                 i, valid, serialout, busy);
        fails++;
      end
    end
    en = 1'b1;
    for (int i = 4; i < 8; i++) begin
      step();
      if (valid === 1'b1) nvalid++;
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i]) begin
        $display("FAIL stall_post_bit%0d: got v=%b s=%b expected v=1 s=%b",
                 i, valid, serialout, exp[7-i]);
        fails++;
      end
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL stall_done: got d=%b expected d=1", done);
      fails++;
    end
    tests++;
    if (nvalid != 8) begin
      $display("FAIL stall_valid_count: got %0d expected 8", nvalid);
      fails++;
    end
    step();
  endtask

  task automatic test_ignored();
    logic [7:0] exp;
    exp = 8'b1011_0101;
    data_in = 8'hB5; repeat_n = 4'd0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start = 1'b1; data_in = 8'h00; repeat_n = 4'hF;
      end else if (i == 4) begin
        start = 1'b0;
      end
      step();
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i]) begin
        $display("FAIL ignored_mid_bit%0d: got v=%b s=%b expected v=1 s=%b",
                 i, valid, serialout, exp[7-i]);
        fails++;
      end
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL ignored_mid_done: got d=%b expected d=1", done);
      fails++;
    end
    step();

    // Second frame: start held high throughout, data changed after capture.
    exp = 8'b0011_1100;
    data_in = 8'h3C; repeat_n = 4'd0; start = 1'b1;
    step();
    data_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i]) begin
        $display("FAIL ignored_held_bit%0d: got v=%b s=%b expected v=1 s=%b",
                 i, valid, serialout, exp[7-i]);
        fails++;
      end
    end
    step();
    tests++;
    if (state !== 3'd3) begin
      $display("FAIL ignored_held_done: got st=%0d expected 3", state);
      fails++;
    end
    step();
    tests++;
    if (state !== 3'd0) begin
      $display("FAIL ignored_start_in_done: got st=%0d expected 0", state);
      fails++;
    end
    step();
    tests++;
    if (state !== 3'd1) begin
      $display("FAIL ignored_restart_idle: got st=%0d expected 1", state);
      fails++;
    end
    start = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    exp = 8'b1011_0101;
    data_in = 8'hB5; repeat_n = 4'd0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (valid !== 1'b1 || serialout !== exp[3]) begin
      $display("FAIL abort_pre_bit4: got v=%b s=%b expected v=1 s=%b", valid, serialout, exp[3]);
      fails++;
    end
    rst = 1'b0;
    step();
    tests++;
    if ({state, serialout, valid, busy, done} !== 7'b0) begin
      $display("FAIL abort_outputs: got %b expected 0000000", {state, serialout, valid, busy, done});
      fails++;
    end
    rst = 1'b1;
    step();
    tests++;
    if (done !== 1'b0 || state !== 3'd0) begin
      $display("FAIL abort_no_done: got d=%b st=%0d expected d=0 st=0", done, state);
      fails++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (valid !== 1'b1 || serialout !== exp[7-i]) begin
        $display("FAIL abort_restart_bit%0d: got v=%b s=%b expected v=1 s=%b",
                 i, valid, serialout, exp[7-i]);
        fails++;
      end
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL abort_restart_done: got d=%b expected d=1", done);
      fails++;
    end
    step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; en = 1'b0; data_in = 8'h00; repeat_n = 4'd0;
    test_reset();
    test_single_frame();
    test_repeat();
    test_stall();
    test_ignored();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
